// File: rtl/ext_data_bus_responder.sv
// ext_data_bus_responder
// Board-side model of an off-chip 8-bit peripheral/SRAM on the external data
// bus. Resolves the shared data net between the pad drivers and this
// responder, serves strobed reads/writes from a 256x8 store with programmable
// wait states, and reports per-cycle bus contention.
//
// Optional feature macro: BUS_KEEPER_EN
//   defined   -> an undriven net bit holds its previous PadI value (bus hold)
//   undefined -> an undriven net bit resolves to 1 (board pull-up)
//
// Handshake: an access is open while CSn and the relevant strobe (RDn or WRn)
// are held low. Ready is high while read data is valid or a write has been
// committed, and drops at the edge that samples the strobe release. A new
// access is only accepted from IDLE, so a strobe seen together with a release
// is re-evaluated on the following cycle.
module ext_data_bus_responder #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [7:0]  INIT_VALUE  = 8'hFF
) (
    input  logic       MasterClock,
    input  logic       Reset,
    input  logic [7:0] PadO,
    input  logic [7:0] PadE,
    input  logic [7:0] Addr,
    input  logic       CSn,
    input  logic       RDn,
    input  logic       WRn,
    output logic [7:0] PadI,
    output logic       Ready,
    output logic       Contention,
    output logic [2:0] DbgState
);

    localparam logic [3:0] WC_LOAD = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_DRIVE = 3'd2,
        ST_WR_WAIT  = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_e;

    state_e      state_q;
    logic [3:0]  wc_q;
    logic [7:0]  addr_q;
    logic [7:0]  drv_q;
    logic        drv_en_q;
    logic        ready_q;
    logic [7:0]  padi_q;
    logic        cont_q;
    logic [7:0]  mem_q [256];

    logic [7:0]  net_d;
    logic [7:0]  pad_drv;
    logic [7:0]  rsp_drv;
    logic [7:0]  both_drv;
    logic        rd_held;
    logic        wr_held;
    logic        rd_req;
    logic        wr_req;
    logic        wr_commit;

    // Strobe decode; a request with both RDn and WRn low is illegal and ignored
    always_comb begin
        rd_held   = ~CSn & ~RDn;
        wr_held   = ~CSn & ~WRn;
        rd_req    = rd_held & WRn;
        wr_req    = wr_held & RDn;
        wr_commit = (state_q == ST_WR_WAIT) && wr_held && (wc_q == 4'd0);
    end

    // Per-bit net resolution: wired-AND when both ends drive, else the
    // single driver, else the pull-up or the keeper
    always_comb begin
        net_d    = 8'hFF;
        pad_drv  = ~PadE;
        rsp_drv  = {8{drv_en_q}};
        both_drv = pad_drv & rsp_drv;
        for (int i = 0; i < 8; i++) begin
            if (both_drv[i]) begin
                net_d[i] = PadO[i] & drv_q[i];
            end else if (pad_drv[i]) begin
                net_d[i] = PadO[i];
            end else if (rsp_drv[i]) begin
                net_d[i] = drv_q[i];
            end else begin
`ifdef BUS_KEEPER_EN
                net_d[i] = padi_q[i];
`else
                net_d[i] = 1'b1;
`endif
            end
        end
    end

    // Register the resolved net and the contention flag of the previous cycle
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            padi_q <= 8'hFF;
            cont_q <= 1'b0;
        end else begin
            padi_q <= net_d;
            cont_q <= |both_drv;
        end
    end

    // Access state machine: wait-state countdown, responder driver and Ready
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            wc_q     <= 4'd0;
            addr_q   <= 8'h00;
            drv_q    <= 8'h00;
            drv_en_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q  <= 1'b0;
                    drv_en_q <= 1'b0;
                    if (rd_req) begin
                        addr_q  <= Addr;
                        wc_q    <= WC_LOAD;
                        state_q <= ST_RD_WAIT;
                    end else if (wr_req) begin
                        addr_q  <= Addr;
                        wc_q    <= WC_LOAD;
                        state_q <= ST_WR_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (!rd_held) begin
                        state_q <= ST_IDLE;
                    end else if (wc_q == 4'd0) begin
                        drv_q    <= mem_q[addr_q];
                        drv_en_q <= 1'b1;
                        state_q  <= ST_RD_DRIVE;
                    end else begin
                        wc_q <= wc_q - 4'd1;
                    end
                end
                ST_RD_DRIVE: begin
                    if (!rd_held) begin
                        drv_en_q <= 1'b0;
                        ready_q  <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_WR_WAIT: begin
                    if (!wr_held) begin
                        state_q <= ST_IDLE;
                    end else if (wc_q == 4'd0) begin
                        ready_q <= 1'b1;
                        state_q <= ST_WR_HOLD;
                    end else begin
                        wc_q <= wc_q - 4'd1;
                    end
                end
                ST_WR_HOLD: begin
                    if (!wr_held) begin
                        ready_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    drv_en_q <= 1'b0;
                    ready_q  <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    // Backing store; a write captures the net value that is about to load PadI
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= INIT_VALUE;
            end
        end else if (wr_commit) begin
            mem_q[addr_q] <= net_d;
        end
    end

    assign PadI       = padi_q;
    assign Ready      = ready_q;
    assign Contention = cont_q;
    assign DbgState   = state_q;

endmodule

// File: tb/tb_ext_data_bus_responder.sv
// Testbench for ext_data_bus_responder: directed scenarios followed by random
// read/write traffic, checked against a transaction-level memory model.
module tb_ext_data_bus_responder;

    localparam int         WS   = 2;
    localparam logic [7:0] INIT = 8'hFF;
`ifdef BUS_KEEPER_EN
    localparam bit KEEPER = 1'b1;
`else
    localparam bit KEEPER = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] pad_o;
    logic [7:0] pad_e;
    logic [7:0] addr;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] pad_i;
    logic       ready;
    logic       contention;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [256];

    ext_data_bus_responder #(
        .WAIT_STATES(WS),
        .INIT_VALUE (INIT)
    ) dut (
        .MasterClock(clk),
        .Reset      (rst),
        .PadO       (pad_o),
        .PadE       (pad_e),
        .Addr       (addr),
        .CSn        (cs_n),
        .RDn        (rd_n),
        .WRn        (wr_n),
        .PadI       (pad_i),
        .Ready      (ready),
        .Contention (contention),
        .DbgState   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem_m[i] = INIT;
    endtask

    // Wait for Ready, counting sample points after the strobe was driven
    task automatic wait_ready(output int lat);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat == 1) addr = 8'($urandom);  // must be ignored by the DUT
            if (ready === 1'b1 || lat >= 40) break;
        end
    endtask

    // Full read access: strobe, data check, release and post-release net check
    task automatic do_read(input logic [7:0] a, input logic [7:0] pe, input logic [7:0] po);
        int lat;
        logic [7:0] exp_data;
        logic [7:0] exp_post;
        pad_e = pe; pad_o = po; addr = a;
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
        wait_ready(lat);
        // Strobe sampled at edge N; data and Ready visible after N+2+WS
        check("rd_latency", 32'(lat), 32'(WS + 3));
        exp_data = mem_m[a] & (po | pe);
        check("rd_data", 32'(pad_i), 32'(exp_data));
        check("rd_contention", 32'(contention), 32'(|(~pe)));
        cs_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        check("rd_release_ready", 32'(ready), 32'd0);
        @(negedge clk);
        exp_post = (po & ~pe) | (pe & (KEEPER ? exp_data : 8'hFF));
        check("rd_release_net", 32'(pad_i), 32'(exp_post));
        @(negedge clk);
    endtask

    // Full write access with all pads driving the data
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        int lat;
        pad_e = 8'h00; pad_o = d; addr = a;
        cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
        wait_ready(lat);
        // Commit and Ready at edge N+1+WS
        check("wr_latency", 32'(lat), 32'(WS + 2));
        check("wr_contention", 32'(contention), 32'd0);
        check("wr_net", 32'(pad_i), 32'(d));
        mem_m[a] = d;
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        check("wr_release_ready", 32'(ready), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] ra;
        model_reset();
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        pad_e = 8'hFF; pad_o = 8'h00; addr = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_padi", 32'(pad_i), 32'hFF);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_contention", 32'(contention), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read of an untouched location with all pads released
        do_read(8'h3C, 8'hFF, 8'h00);

        // Write then read back with pads released
        do_write(8'h10, 8'hA5);
        do_read(8'h10, 8'hFF, 8'h00);

        // Read while the pads fight the responder
        do_read(8'h10, 8'h00, 8'h0F);

        // Release after driving 8'h5A with no access
        pad_e = 8'h00; pad_o = 8'h5A;
        repeat (2) @(negedge clk);
        check("hold_driven", 32'(pad_i), 32'h5A);
        pad_e = 8'hFF;
        @(negedge clk);
        check("hold_release_1", 32'(pad_i), KEEPER ? 32'h5A : 32'hFF);
        @(negedge clk);
        check("hold_release_2", 32'(pad_i), KEEPER ? 32'h5A : 32'hFF);

        // Illegal strobe combination: no access, no Ready, no store change
        pad_e = 8'h00; pad_o = 8'h3C; addr = 8'h10;
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        for (int i = 0; i < WS + 4; i++) begin
            @(negedge clk);
            check("illegal_ready", 32'(ready), 32'd0);
            check("illegal_contention", 32'(contention), 32'd0);
        end
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        repeat (2) @(negedge clk);
        do_read(8'h10, 8'hFF, 8'h00);

        // Read aborted mid-wait: the responder must never drive
        pad_e = 8'h00; pad_o = 8'h00; addr = 8'h10;
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
        repeat (2) @(negedge clk);
        rd_n = 1'b1;
        for (int i = 0; i < WS + 4; i++) begin
            @(negedge clk);
            check("abort_ready", 32'(ready), 32'd0);
            check("abort_contention", 32'(contention), 32'd0);
            check("abort_net", 32'(pad_i), 32'h00);
        end
        cs_n = 1'b1;
        @(negedge clk);

        // Reset during WR_WAIT discards the write and reloads the whole store
        pad_e = 8'h00; pad_o = 8'h77; addr = 8'h20;
        cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        check("midreset_padi", 32'(pad_i), 32'hFF);
        check("midreset_ready", 32'(ready), 32'd0);
        check("midreset_contention", 32'(contention), 32'd0);
        rst = 1'b0;
        model_reset();
        pad_e = 8'hFF;
        @(negedge clk);
        do_read(8'h20, 8'hFF, 8'h00);
        do_read(8'h10, 8'hFF, 8'h00);

        // Random traffic over a small address window to force reuse
        for (int n = 0; n < 30; n++) begin
            ra = 8'($urandom_range(0, 7));
            if (n % 5 == 4) ra = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                do_write(ra, 8'($urandom));
            end else begin
                do_read(ra, 8'($urandom), 8'($urandom));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
